// File: rtl/vram_port_arbiter.sv
// VRAM port-A arbiter: shares one registered access slot between the CPU bus and the DMA copy engine.
// Optional PPU mode-3 CPU lockout is compiled in when VRAM_LOCK_EN is defined.
module vram_port_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter logic [1:0] LOCK_MODE = 2'd3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        ppu_mode,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {GRANT_CPU, GRANT_DMA} grant_t;

  state_t state, state_nx;
  grant_t last_grant, last_grant_nx;
  logic win_cpu, win_cpu_nx;
  logic rd_pend, rd_pend_nx;
  logic blocked, blocked_nx;
  logic vram_we_nx, cpu_ack_nx, dma_ack_nx;
  logic [ADDR_W-1:0] vram_addr_nx;
  logic [DATA_W-1:0] vram_wdata_nx, cpu_rdata_nx;

  logic locked;
  logic cpu_eligible, dma_eligible, grant_cpu;

`ifdef VRAM_LOCK_EN
  assign locked = (ppu_mode == LOCK_MODE);
`else
  logic unused_lock;
  assign locked = 1'b0;
  assign unused_lock = ^{ppu_mode, LOCK_MODE};
`endif

  // A locked CPU access is still granted (and answered), only DMA has to wait.
  assign cpu_eligible = cpu_req;
  assign dma_eligible = dma_req & ~locked;
  assign grant_cpu    = cpu_eligible & (~dma_eligible | (last_grant == GRANT_DMA));

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    win_cpu_nx    = win_cpu;
    rd_pend_nx    = rd_pend;
    blocked_nx    = blocked;
    vram_we_nx    = vram_we;
    vram_addr_nx  = vram_addr;
    vram_wdata_nx = vram_wdata;
    cpu_rdata_nx  = cpu_rdata;
    cpu_ack_nx    = 1'b0;
    dma_ack_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_eligible | dma_eligible) begin
          state_nx   = ACCESS;
          win_cpu_nx = grant_cpu;
          if (grant_cpu) begin
            last_grant_nx = GRANT_CPU;
            vram_addr_nx  = cpu_addr;
            vram_wdata_nx = cpu_wdata;
            vram_we_nx    = cpu_we & ~locked;
            rd_pend_nx    = ~cpu_we;
            blocked_nx    = locked;
          end else begin
            last_grant_nx = GRANT_DMA;
            vram_addr_nx  = dma_addr;
            vram_wdata_nx = dma_wdata;
            vram_we_nx    = 1'b1;
            rd_pend_nx    = 1'b0;
            blocked_nx    = 1'b0;
          end
        end
      end
      ACCESS: begin
        // The lock decision was frozen at grant, so a mode change now has no effect.
        state_nx   = DONE;
        vram_we_nx = 1'b0;
        cpu_ack_nx = win_cpu;
        dma_ack_nx = ~win_cpu;
        if (win_cpu & rd_pend)
          cpu_rdata_nx = blocked ? {DATA_W{1'b1}} : vram_rdata;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= GRANT_DMA;
      win_cpu    <= 1'b0;
      rd_pend    <= 1'b0;
      blocked    <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      win_cpu    <= win_cpu_nx;
      rd_pend    <= rd_pend_nx;
      blocked    <= blocked_nx;
      vram_we    <= vram_we_nx;
      vram_addr  <= vram_addr_nx;
      vram_wdata <= vram_wdata_nx;
      cpu_rdata  <= cpu_rdata_nx;
      cpu_ack    <= cpu_ack_nx;
      dma_ack    <= dma_ack_nx;
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: directed scenarios then random traffic against a transaction-level model.
// Expectations follow VRAM_LOCK_EN when it is defined for the build.
module tb_vram_port_arbiter;

`ifdef VRAM_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  ppu_mode;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        dma_req;
  logic [12:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic        vram_we;
  logic [12:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata;

  logic [7:0] vram_mem [8192];
  logic [7:0] ref_mem [8192];
  bit         last_dma;
  logic [7:0] rdata_m;
  int n_checks = 0;
  int n_fail = 0;

  vram_port_arbiter dut (
    .clk(clk), .reset_n(reset_n), .ppu_mode(ppu_mode),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-A side of the video RAM: write at the clock edge, combinational read.
  always @(posedge clk) if (vram_we) vram_mem[vram_addr] <= vram_wdata;
  assign vram_rdata = vram_mem[vram_addr];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic we, input logic [12:0] addr, input logic [7:0] data);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
  endtask

  task automatic set_dma(input logic [12:0] addr, input logic [7:0] data);
    dma_req = 1'b1; dma_addr = addr; dma_wdata = data;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_we"}, vram_we, 0);
    check_output({tag, "_addr"}, vram_addr, 0);
    check_output({tag, "_wdata"}, vram_wdata, 0);
    check_output({tag, "_cack"}, cpu_ack, 0);
    check_output({tag, "_dack"}, dma_ack, 0);
    check_output({tag, "_rdata"}, cpu_rdata, 0);
  endtask

  // Called during an IDLE cycle with requests already driven; returns in the next IDLE cycle.
  task automatic serve_one(input bit scramble);
    bit locked, ce, de, win_cpu, wr, blk;
    logic [12:0] addr;
    logic [7:0]  data;
    locked = LOCK_ON && (ppu_mode == 2'd3);
    ce = cpu_req;
    de = dma_req && !locked;
    if (!ce && !de) begin
      @(posedge clk); @(negedge clk);
      check_output("idle_we", vram_we, 0);
      check_output("idle_cack", cpu_ack, 0);
      check_output("idle_dack", dma_ack, 0);
      return;
    end
    win_cpu = ce && (!de || last_dma);
    wr   = win_cpu ? cpu_we : 1'b1;
    blk  = win_cpu && locked;
    addr = win_cpu ? cpu_addr : dma_addr;
    data = win_cpu ? cpu_wdata : dma_wdata;

    @(posedge clk); #1;
    if (scramble) ppu_mode = 2'($urandom_range(0, 3));
    @(negedge clk);
    check_output("acc_we", vram_we, (wr && !blk) ? 1 : 0);
    check_output("acc_addr", vram_addr, addr);
    if (wr && !blk) check_output("acc_wdata", vram_wdata, data);
    check_output("acc_cack", cpu_ack, 0);
    check_output("acc_dack", dma_ack, 0);
    check_output("acc_rdata_hold", cpu_rdata, rdata_m);

    last_dma = !win_cpu;
    if (wr && !blk) ref_mem[addr] = data;
    if (win_cpu && !wr) rdata_m = blk ? 8'hFF : ref_mem[addr];

    @(posedge clk); @(negedge clk);
    check_output("ack_cpu", cpu_ack, win_cpu ? 1 : 0);
    check_output("ack_dma", dma_ack, win_cpu ? 0 : 1);
    check_output("ack_we_clear", vram_we, 0);
    check_output("ack_rdata", cpu_rdata, rdata_m);
    check_output("mem_content", vram_mem[addr], ref_mem[addr]);

    @(posedge clk); #1;
    if (win_cpu) cpu_req = 1'b0; else dma_req = 1'b0;
    @(negedge clk);
    check_output("post_cack", cpu_ack, 0);
    check_output("post_dack", dma_ack, 0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      vram_mem[i] <= 8'h00;
      ref_mem[i] = 8'h00;
    end
    last_dma = 1'b1;
    rdata_m  = 8'h00;
    reset_n = 1'b0; ppu_mode = 2'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_addr = '0; dma_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;

    $display("[TB] simultaneous requests after reset");
    set_cpu(1'b1, 13'h0100, 8'h11);
    set_dma(13'h0101, 8'h22);
    serve_one(1'b0);
    serve_one(1'b0);
    check_output("sim_mem_cpu", vram_mem[13'h0100], 8'h11);
    check_output("sim_mem_dma", vram_mem[13'h0101], 8'h22);

    $display("[TB] CPU write then read, mode 0");
    set_cpu(1'b1, 13'h0010, 8'hA5);
    serve_one(1'b0);
    set_cpu(1'b0, 13'h0010, 8'h00);
    serve_one(1'b0);
    check_output("wr_rd_data", cpu_rdata, 8'hA5);

    $display("[TB] sustained contention");
    set_cpu(1'b1, 13'h0500, 8'h30);
    set_dma(13'h0580, 8'h40);
    for (int k = 1; k <= 6; k++) begin
      serve_one(1'b0);
      if (k < 6) begin
        if (!cpu_req) set_cpu(1'b1, 13'h0500 + 13'(k), 8'h30 + 8'(k));
        if (!dma_req) set_dma(13'h0580 + 13'(k), 8'h40 + 8'(k));
      end
    end
    serve_one(1'b0);

    $display("[TB] PPU mode 3 scenario");
    ppu_mode = 2'd3;
    set_cpu(1'b1, 13'h0200, 8'h55);
    serve_one(1'b0);
    set_cpu(1'b0, 13'h0200, 8'h00);
    serve_one(1'b0);
    check_output("lock_read", cpu_rdata, LOCK_ON ? 8'hFF : 8'h55);
    check_output("lock_mem", vram_mem[13'h0200], LOCK_ON ? 8'h00 : 8'h55);
    set_dma(13'h0201, 8'h66);
    repeat (3) serve_one(1'b0);
    ppu_mode = 2'd0;
    serve_one(1'b0);
    check_output("lock_dma_mem", vram_mem[13'h0201], 8'h66);

    $display("[TB] reset during ACCESS");
    set_cpu(1'b1, 13'h0300, 8'h77);
    @(posedge clk); #1;
    reset_n = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check_output("rma_we_access", vram_we, 1);
    @(posedge clk); @(negedge clk);
    check_reset_values("rma");
    @(posedge clk); @(negedge clk);
    check_output("rma_cack_late", cpu_ack, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    last_dma = 1'b1;
    rdata_m  = 8'h00;
    set_cpu(1'b1, 13'h0310, 8'h12);
    set_dma(13'h0311, 8'h34);
    serve_one(1'b0);
    serve_one(1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 250; n++) begin
      if (!cpu_req && $urandom_range(0, 1) == 1)
        set_cpu(1'($urandom_range(0, 1)), 13'h0400 + 13'($urandom_range(0, 15)), 8'($urandom));
      if (!dma_req && $urandom_range(0, 1) == 1)
        set_dma(13'h0400 + 13'($urandom_range(0, 15)), 8'($urandom));
      ppu_mode = 2'($urandom_range(0, 3));
      serve_one(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
